mem_port_arbiter: RTL

Shares the single unified memory port of the pipelined MIPS core between the instruction-fetch stage and the MEM stage (lw/lh/lhu/lb/lbu/sw/sh/sb). It serialises the two requesters onto one memory handshake and performs byte-lane steering and load extension from the decoder's Memrhalf/Memrbyte/MemExt controls. It returns per-requester ready pulses that the pipeline uses as stall releases. Data accesses have priority, and a bounded-run counter guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one memory port between instruction fetch and the MEM
//                stage, with store lane steering and load extension.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MAX_DATA_RUN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_half,
    input  logic        d_byte,
    input  logic        d_ext,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_BUSY_I  = 2'd1;
    localparam logic [1:0] c_BUSY_D  = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;
    localparam logic [3:0] c_RUN_MAX = 4'(MAX_DATA_RUN);

    logic [1:0]  r_state;
    logic [3:0]  r_run_cnt;
    logic        r_is_d;
    logic [1:0]  r_lane;
    logic        r_half;
    logic        r_byte;
    logic        r_ext;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        r_if_ready;
    logic        r_d_ready;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_run_full;
    logic        w_grant_d;
    logic        w_grant_i;
    logic [31:0] w_g_addr;
    logic        w_g_we;
    logic        w_g_half;
    logic        w_g_byte;
    logic        w_g_ext;
    logic        w_misalign;
    logic [3:0]  w_g_be;
    logic [31:0] w_g_wdata;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load;

    // Data wins unless fetch has been waiting through a full data run.
    always_comb begin
        w_run_full = (r_run_cnt >= c_RUN_MAX);
        w_grant_d  = d_req && !(if_req && w_run_full);
        w_grant_i  = if_req && !w_grant_d;
        w_g_addr   = w_grant_d ? d_addr : if_addr;
        w_g_we     = w_grant_d && d_we;
        w_g_half   = w_grant_d && d_half && !d_byte;
        w_g_byte   = w_grant_d && d_byte;
        w_g_ext    = w_grant_d && d_ext;

        if (w_g_byte) begin
            w_misalign = 1'b0;
        end else if (w_g_half) begin
            w_misalign = w_g_addr[0];
        end else begin
            w_misalign = |w_g_addr[1:0];
        end

        w_g_be    = 4'b1111;
        w_g_wdata = 32'd0;
        if (w_g_we) begin
            if (w_g_byte) begin
                w_g_be    = 4'b0001 << w_g_addr[1:0];
                w_g_wdata = {4{d_wdata[7:0]}};
            end else if (w_g_half) begin
                w_g_be    = w_g_addr[1] ? 4'b1100 : 4'b0011;
                w_g_wdata = {2{d_wdata[15:0]}};
            end else begin
                w_g_wdata = d_wdata;
            end
        end
    end

    // Fetches are latched as zero-extended word loads, so they pass through.
    always_comb begin
        case (r_lane)
            2'd1:    w_lane_byte = mem_rdata[15:8];
            2'd2:    w_lane_byte = mem_rdata[23:16];
            2'd3:    w_lane_byte = mem_rdata[31:24];
            default: w_lane_byte = mem_rdata[7:0];
        endcase
        w_lane_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (r_byte) begin
            w_load = {{24{r_ext & w_lane_byte[7]}}, w_lane_byte};
        end else if (r_half) begin
            w_load = {{16{r_ext & w_lane_half[15]}}, w_lane_half};
        end else begin
            w_load = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_run_cnt   <= 4'd0;
            r_is_d      <= 1'b0;
            r_lane      <= 2'd0;
            r_half      <= 1'b0;
            r_byte      <= 1'b0;
            r_ext       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'd0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_rdata     <= 32'd0;
            r_err       <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_grant_d || w_grant_i) begin
                        r_is_d <= w_grant_d;
                        r_lane <= w_g_addr[1:0];
                        r_half <= w_g_half;
                        r_byte <= w_g_byte;
                        r_ext  <= w_g_ext;
                        if (w_grant_i) begin
                            r_run_cnt <= 4'd0;
                        end else if (if_req && !w_run_full) begin
                            r_run_cnt <= r_run_cnt + 4'd1;
                        end
                        if (w_misalign) begin
                            r_state    <= c_RESP;
                            r_rdata    <= 32'd0;
                            r_err      <= 1'b1;
                            r_d_ready  <= w_grant_d;
                            r_if_ready <= w_grant_i;
                        end else begin
                            r_state     <= w_grant_d ? c_BUSY_D : c_BUSY_I;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_g_we;
                            r_mem_addr  <= {w_g_addr[31:2], 2'b00};
                            r_mem_be    <= w_g_be;
                            r_mem_wdata <= w_g_wdata;
                        end
                    end
                end
                c_BUSY_I, c_BUSY_D: begin
                    if (mem_ready) begin
                        r_state     <= c_RESP;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= 32'd0;
                        r_mem_be    <= 4'd0;
                        r_mem_wdata <= 32'd0;
                        r_rdata     <= w_load;
                        r_err       <= 1'b0;
                        r_d_ready   <= r_is_d;
                        r_if_ready  <= !r_is_d;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // One capture register serves both requesters; only the pulsed one looks.
    assign if_ready  = r_if_ready;
    assign if_rdata  = r_rdata;
    assign if_err    = r_err;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_rdata;
    assign d_err     = r_err;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;

endmodule
`default_nettype wire
